alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage.sv | 133 +++++++++++++
 tb/tb_alu_decode_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// ALU control decode stage: maps RV32I/RV32M fields to an ALU op code and holds it
// behind a valid/ready handshake, stretching MUL/DIV ops over their occupancy.
module alu_decode_stage #(
    parameter bit          M_EXT   = 1'b1,
    parameter int unsigned CTRL_W  = 5,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              mdu_op,
    output logic              illegal,
    output logic              busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [4:0] OP_R   = 5'b01100;
    localparam logic [4:0] OP_I   = 5'b00100;
    localparam logic [4:0] OP_LUI = 5'b01101;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              capture;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_mdu;
    logic              dec_ill;
    logic              dec_multi;
    logic [CNT_W-1:0]  dec_cnt;

    // Field decode of the instruction presented this cycle
    always_comb begin
        dec_code  = '0;
        dec_mdu   = 1'b0;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_cnt   = '0;
        if (opcode == OP_R && funct7b0) begin
            if (M_EXT) begin
                dec_code = CTRL_W'({2'b10, funct3});
                dec_mdu  = 1'b1;
                if (funct3[2]) begin
                    dec_multi = (DIV_LAT > 1);
                    dec_cnt   = CNT_W'(DIV_LAT - 1);
                end else begin
                    dec_multi = (MUL_LAT > 1);
                    dec_cnt   = CNT_W'(MUL_LAT - 1);
                end
            end else begin
                dec_ill = 1'b1;
            end
        end else if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                3'b000:  dec_code = CTRL_W'((opcode == OP_R && funct7b5) ? 4'd1 : 4'd0);
                3'b010:  dec_code = CTRL_W'(4'd2);
                3'b011:  dec_code = CTRL_W'(4'd3);
                3'b100:  dec_code = CTRL_W'(4'd4);
                3'b110:  dec_code = CTRL_W'(4'd5);
                3'b111:  dec_code = CTRL_W'(4'd6);
                3'b001:  dec_code = CTRL_W'(4'd7);
                default: dec_code = CTRL_W'(funct7b5 ? 4'd9 : 4'd8);
            endcase
        end else if (opcode == OP_LUI) begin
            dec_code = CTRL_W'(4'd15);
        end
    end

    // Flush blocks acceptance combinationally so a flushed cycle never captures
    assign in_ready  = !flush && ((state == S_EMPTY) || (state == S_FULL && out_ready));
    assign capture   = in_valid && in_ready;
    assign out_valid = (state == S_FULL);
    assign busy      = (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            cnt         <= '0;
            alu_control <= '0;
            mdu_op      <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            state   <= S_EMPTY;
            cnt     <= '0;
            mdu_op  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_EMPTY, S_FULL: begin
                    if (capture) begin
                        alu_control <= dec_code;
                        mdu_op      <= dec_mdu;
                        illegal     <= dec_ill;
                        state       <= dec_multi ? S_WAIT : S_FULL;
                        cnt         <= dec_multi ? dec_cnt : '0;
                    end else if (state == S_FULL && out_ready) begin
                        state <= S_EMPTY;
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FULL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_EMPTY;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: an RV32M build and an RV32I-only build share one
// stimulus stream and are each checked every cycle against a transaction-level model.
module tb_alu_decode_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;
    logic       flush;
    logic       out_ready;

    logic       in_ready0, out_valid0, mdu0, ill0, busy0;
    logic [4:0] alu0;
    logic       in_ready1, out_valid1, mdu1, ill1, busy1;
    logic [3:0] alu1;

    alu_decode_stage #(.M_EXT(1'b1), .CTRL_W(5), .MUL_LAT(4), .DIV_LAT(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .alu_control(alu0), .mdu_op(mdu0), .illegal(ill0), .busy(busy0)
    );

    alu_decode_stage #(.M_EXT(1'b0), .CTRL_W(4), .MUL_LAT(3), .DIV_LAT(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .alu_control(alu1), .mdu_op(mdu1), .illegal(ill1), .busy(busy1)
    );

    logic       ir [2];
    logic       ov [2];
    logic       md [2];
    logic       il [2];
    logic       bs [2];
    logic [4:0] ac [2];
    assign ir[0] = in_ready0;  assign ir[1] = in_ready1;
    assign ov[0] = out_valid0; assign ov[1] = out_valid1;
    assign md[0] = mdu0;       assign md[1] = mdu1;
    assign il[0] = ill0;       assign il[1] = ill1;
    assign bs[0] = busy0;      assign bs[1] = busy1;
    assign ac[0] = alu0;       assign ac[1] = {1'b0, alu1};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int i, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    function automatic bit mext_of(input int i);
        return (i == 0);
    endfunction

    function automatic int lat_of(input int i, input bit is_div);
        if (i == 0) return is_div ? 8 : 4;
        return is_div ? 5 : 3;
    endfunction

    // Reference decode from the instruction-set tables
    function automatic logic [4:0] ref_code(input bit mext, input logic [4:0] op, input logic [2:0] f3,
                                            input logic b5, input logic b0);
        logic [4:0] tbl [8];
        logic [4:0] code;
        tbl = '{5'd0, 5'd7, 5'd2, 5'd3, 5'd4, 5'd8, 5'd5, 5'd6};
        if (op == 5'b01100 && b0) return mext ? (5'd16 + 5'(f3)) : 5'd0;
        if (op == 5'b01101) return 5'd15;
        if (op != 5'b01100 && op != 5'b00100) return 5'd0;
        code = tbl[f3];
        if (f3 == 3'd0 && op == 5'b01100 && b5) code = 5'd1;
        if (f3 == 3'd5 && b5) code = 5'd9;
        return code;
    endfunction

    // Model: held op fields, whether it is presented, and cycles left before it is
    int         rem  [2];
    bit         have [2];
    logic [4:0] mcode[2];
    bit         mmdu [2];
    bit         mill [2];
    bit         mvalid = 1'b0;

    function automatic bit exp_ready(input int i);
        return !flush && rem[i] == 0 && (!have[i] || out_ready);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rem[i] = 0; have[i] = 0; mcode[i] = 5'd0; mmdu[i] = 0; mill[i] = 0;
            end else if (flush) begin
                rem[i] = 0; have[i] = 0; mmdu[i] = 0; mill[i] = 0;
            end else if (in_valid && exp_ready(i)) begin
                bit mop;
                int lat;
                mop      = (opcode == 5'b01100) && funct7b0;
                mcode[i] = ref_code(mext_of(i), opcode, funct3, funct7b5, funct7b0);
                mmdu[i]  = mop && mext_of(i);
                mill[i]  = mop && !mext_of(i);
                lat      = mmdu[i] ? lat_of(i, funct3[2]) : 1;
                have[i]  = (lat == 1);
                rem[i]   = lat - 1;
            end else if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) have[i] = 1;
            end else if (have[i] && out_ready) begin
                have[i] = 0;
            end
        end
        if (!rst_n) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                check("in_ready",    i, 5'(ir[i]), 5'(exp_ready(i)));
                check("out_valid",   i, 5'(ov[i]), 5'(have[i]));
                check("busy",        i, 5'(bs[i]), 5'(rem[i] > 0));
                check("alu_control", i, ac[i], mcode[i]);
                check("mdu_op",      i, 5'(md[i]), 5'(mmdu[i]));
                check("illegal",     i, 5'(il[i]), 5'(mill[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [2:0] f3, input logic b5, input logic b0);
        opcode = op; funct3 = f3; funct7b5 = b5; funct7b0 = b0;
    endtask

    logic [4:0] bs_op [4];
    logic [2:0] bs_f3 [4];
    logic       bs_b5 [4];
    logic [4:0] bs_exp[4];

    initial begin
        clk = 0; rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
        set_op(5'd0, 3'd0, 1'b0, 1'b0);
        bs_op  = '{5'b01100, 5'b00100, 5'b00100, 5'b01101};
        bs_f3  = '{3'd0, 3'd0, 3'd5, 3'd0};
        bs_b5  = '{1'b1, 1'b1, 1'b1, 1'b0};
        bs_exp = '{5'b00001, 5'b00000, 5'b01001, 5'b01111};

        tick(); tick();
        check("rst_alu", 0, alu0, 5'd0);
        check("rst_valid", 0, 5'(out_valid0), 5'd0);
        check("rst_mdu", 0, 5'(mdu0), 5'd0);
        rst_n = 1;
        #1 check("rel_ready", 0, 5'(in_ready0), 5'd1);

        // Back-to-back single-cycle ops
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1;
            set_op(bs_op[k], bs_f3[k], bs_b5[k], 1'b0);
            #1 check("stream_ready", 0, 5'(in_ready0), 5'd1);
            tick();
            check("stream_code", 0, alu0, bs_exp[k]);
            check("stream_valid", 0, 5'(out_valid0), 5'd1);
        end
        in_valid = 0;
        tick();

        // DIV occupancy on the M build; illegal single-cycle on the base build
        set_op(5'b01100, 3'd4, 1'b0, 1'b1);
        in_valid = 1;
        tick();
        in_valid = 0;
        check("div_ill_b", 1, 5'(ill1), 5'd1);
        check("div_code_b", 1, 5'(alu1), 5'd0);
        check("div_valid_b", 1, 5'(out_valid1), 5'd1);
        for (int k = 1; k <= 6; k++) begin
            check("div_busy", 0, 5'(busy0), 5'd1);
            check("div_not_valid", 0, 5'(out_valid0), 5'd0);
            tick();
        end
        check("div_busy_last", 0, 5'(busy0), 5'd1);
        tick();
        check("div_valid", 0, 5'(out_valid0), 5'd1);
        check("div_code", 0, alu0, 5'b10100);
        check("div_mdu", 0, 5'(mdu0), 5'd1);
        tick();

        // Backpressure holds the presented op
        set_op(5'b01100, 3'd7, 1'b0, 1'b0);
        in_valid = 1; out_ready = 0;
        tick();
        set_op(5'b01100, 3'd4, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_ready", 0, 5'(in_ready0), 5'd0);
            tick();
            check("bp_hold", 0, alu0, 5'd6);
        end
        out_ready = 1;
        #1 check("bp_release_ready", 0, 5'(in_ready0), 5'd1);
        tick();
        check("bp_next", 0, alu0, 5'd4);
        in_valid = 0;
        tick();

        // Flush while a MUL is pending
        set_op(5'b01100, 3'd0, 1'b0, 1'b1);
        in_valid = 1;
        tick();
        check("mul_busy", 0, 5'(busy0), 5'd1);
        flush = 1;
        #1 check("flush_ready", 0, 5'(in_ready0), 5'd0);
        tick();
        flush = 0; in_valid = 0;
        check("flush_valid", 0, 5'(out_valid0), 5'd0);
        check("flush_busy", 0, 5'(busy0), 5'd0);
        check("flush_mdu", 0, 5'(mdu0), 5'd0);
        check("flush_keep_code", 0, alu0, 5'b10000);
        tick(); tick();
        check("flush_no_late", 0, 5'(out_valid0), 5'd0);

        // Reset while holding under backpressure
        set_op(5'b01101, 3'd0, 1'b0, 1'b0);
        in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        tick();
        check("full_before_rst", 0, alu0, 5'd15);
        rst_n = 0;
        tick();
        check("rst_full_code", 0, alu0, 5'd0);
        check("rst_full_valid", 0, 5'(out_valid0), 5'd0);
        rst_n = 1;
        #1 check("rst_full_ready", 0, 5'(in_ready0), 5'd1);

        // Randomized traffic
        repeat (3000) begin
            int r;
            tick();
            r = $urandom_range(0, 7);
            case (r)
                0, 1, 2: opcode = 5'b01100;
                3, 4:    opcode = 5'b00100;
                5:       opcode = 5'b01101;
                6:       opcode = 5'b00101;
                default: opcode = 5'($urandom);
            endcase
            funct3    = 3'($urandom);
            funct7b5  = 1'($urandom);
            funct7b0  = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
        end
        tick();
        rst_n = 1; flush = 0; in_valid = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
